imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Write-side counterpart of the instruction memory. It receives a program as a little-endian byte stream over a valid/ready handshake, packs each 4 bytes into a 32-bit instruction word, and issues single-cycle word writes into the instruction memory's write port at sequential addresses starting at 0. While loading it holds the processor core stalled. It reports completion or a rejected request.

Parameters:
IMEM_DEPTH, 1024, number of 32-bit words in instruction memory.
IMEM_ADDR_WIDTH, 10, word-address width; must satisfy 2**IMEM_ADDR_WIDTH == IMEM_DEPTH.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  load request; sampled only in IDLE.
word_count  input  IMEM_ADDR_WIDTH+1  number of words to load; sampled with start.
s_valid  input  1  byte-stream valid.
s_data  input  8  byte-stream data.
s_ready  output  1  byte accepted when s_valid && s_ready.
we  output  1  imem write enable; one-cycle pulse per word.
waddr  output  IMEM_ADDR_WIDTH  imem word address.
wdata  output  32  imem write data.
busy  output  1  load in progress.
core_hold  output  1  stall/hold request to core; equal to busy.
done  output  1  one-cycle pulse when a load completes.
err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (async assert, sync release): state=IDLE. Outputs s_ready, we, busy, core_hold, done and err are 0. waddr=0 and wdata=0. The byte index, word address and word counter are cleared.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - If start && word_count==0, go to DONE. No writes occur.
  - If start && word_count>IMEM_DEPTH, err=1 for the next cycle and stay in IDLE. busy stays 0.
  - If start with 1..IMEM_DEPTH words, latch word_count, clear word address and byte index, and go to RECV.
- RECV:
  - s_ready=1 and busy=1.
  - Each accepted byte goes into bits [8*idx+7:8*idx] of the assembly register (byte 0 = LSB), then idx increments.
  - The cycle the 4th byte is accepted, go to WRITE. idx wraps to 0.
  - s_valid low means wait indefinitely. There is no timeout.
- WRITE (one cycle):
  - we=1, waddr=current word address, wdata=assembled word, s_ready=0.
  - Latency: we is high in the cycle immediately after the 4th-byte handshake.
  - Next, the word address increments. If words written == latched count, go to DONE; otherwise go to RECV.
- DONE (one cycle): done=1 and busy=0, then go to IDLE.
- busy=1 exactly in RECV and WRITE. core_hold=busy.
- start while busy, or in DONE, is ignored.
- Address never wraps: the last possible write is waddr=IMEM_DEPTH-1. A counter compare against the latched count, not address overflow, terminates the load.
- Bytes presented after the final word (s_valid in DONE/IDLE) are not accepted (s_ready=0).
- Reset mid-operation: the partial word is discarded and no write is issued. Previously written words remain in imem. The next load restarts at address 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from s_valid to any output.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum (IDLE, RECV, WRITE, DONE), 2-bit;
  - BYTES_PER_WORD=4.
- One natural sub-module: imem_word_packer. It holds the byte index and 32-bit assembly register. Inputs: byte strobe, byte, clear. Outputs: word, word_complete. The FSM, counters and write port stay in imem_loader.

Test Plan:
- Single word: start, word_count=1, bytes 0x13,0x00,0x00,0x00 back-to-back. Expect one we with waddr=0, wdata=0x00000013, then done the next cycle, busy=0.
- Three words with random s_valid gaps: bytes 0x..ef,0xbe,0xad,0xde / 0x01,0x02,0x03,0x04 / 0xff×4. Expect writes (0,0xdeadbeef), (1,0x04030201), (2,0xffffffff) in order. s_ready must not be high during WRITE. One done pulse.
- word_count=0: expect done 1 cycle after start, no we, busy never 1. word_count=1025: expect err pulse, no busy, no we, s_ready stays 0.
- Reset mid-word: assert reset_n=0 after 2 bytes of word 1. Expect no we and all outputs at reset values. A new load of 1 word then writes waddr=0.
- start asserted again during RECV with word_count=5 (original 2): expect it ignored. Exactly 2 writes occur.
- Full depth: word_count=1024. Expect 1024 writes with waddr 0..1023, no wraparound, and done after waddr=1023.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The FSM state encoding and byte-packing geometry live here.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_complete flags the strobe that carries the last byte of a word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [BIDX_W-1:0] idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (strobe) begin
            word[8*idx +: 8] <= din;
            // idx is exactly wide enough to wrap back to 0 after the last byte
            idx              <= idx + BIDX_W'(1);
        end
    end

    assign word_complete = strobe && (idx == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program into instruction memory, one word write per
// four accepted bytes, holding the core stalled for the duration of the load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH      = 1024,
    parameter int IMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [IMEM_ADDR_WIDTH:0]   word_count,
    input  logic                       s_valid,
    input  logic [7:0]                 s_data,
    output logic                       s_ready,
    output logic                       we,
    output logic [IMEM_ADDR_WIDTH-1:0] waddr,
    output logic [31:0]                wdata,
    output logic                       busy,
    output logic                       core_hold,
    output logic                       done,
    output logic                       err
);

    localparam logic [IMEM_ADDR_WIDTH:0] DEPTH_W = (IMEM_ADDR_WIDTH+1)'(IMEM_DEPTH);

    state_t                     state, nstate;
    logic [IMEM_ADDR_WIDTH:0]   count_q;
    logic [IMEM_ADDR_WIDTH:0]   wcnt;
    logic [IMEM_ADDR_WIDTH-1:0] addr;
    logic                       err_q;

    logic        in_idle, launch, reject, zero_req;
    logic        strobe, word_complete, last_word;
    logic [31:0] word;

    assign in_idle   = (state == ST_IDLE);
    assign zero_req  = in_idle && start && (word_count == '0);
    assign reject    = in_idle && start && (word_count > DEPTH_W);
    assign launch    = in_idle && start && !zero_req && !reject;
    assign strobe    = (state == ST_RECV) && s_valid;
    assign last_word = ((wcnt + 1'b1) == count_q);

    imem_word_packer u_packer (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (launch),
        .strobe        (strobe),
        .din           (s_data),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: begin
                if (zero_req)    nstate = ST_DONE;
                else if (launch) nstate = ST_RECV;
            end
            ST_RECV:  if (word_complete) nstate = ST_WRITE;
            ST_WRITE: nstate = last_word ? ST_DONE : ST_RECV;
            ST_DONE:  nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wcnt    <= '0;
            addr    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= reject;
            if (launch) begin
                count_q <= word_count;
                wcnt    <= '0;
                addr    <= '0;
            end else if (state == ST_WRITE) begin
                wcnt <= wcnt + 1'b1;
                // Hold on the final word so a full-depth load never wraps waddr to 0
                if (!last_word) addr <= addr + 1'b1;
            end
        end
    end

    assign s_ready   = (state == ST_RECV);
    assign we        = (state == ST_WRITE);
    assign waddr     = addr;
    assign wdata     = word;
    assign busy      = (state == ST_RECV) || (state == ST_WRITE);
    assign core_hold = busy;
    assign done      = (state == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and popped by a negedge monitor whenever we is seen.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready, we, busy, core_hold, done, err;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr, n_done, n_err;
    bit busy_seen, sready_seen, mon_en;
    logic [AW-1:0] last_wa;

    always #5 clk = ~clk;

    imem_loader #(.IMEM_DEPTH(DEPTH), .IMEM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .we(we),
        .waddr(waddr), .wdata(wdata), .busy(busy), .core_hold(core_hold),
        .done(done), .err(err)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (core_hold !== busy) begin
                n_bad++;
                $display("FAIL core_hold: got %b want %b", core_hold, busy);
            end
            if (we === 1'b1) begin
                exp_t e;
                n_wr++;
                last_wa = waddr;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0d data %h, want no write", waddr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (waddr !== e.a || wdata !== e.d) begin
                        n_bad++;
                        $display("FAIL write: got (%0d,%h) want (%0d,%h)", waddr, wdata, e.a, e.d);
                    end
                end
                n_cmp++;
                if (s_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL sready_in_write: got %b want 0", s_ready);
                end
            end
            if (done === 1'b1) n_done++;
            if (err === 1'b1) n_err++;
            if (busy === 1'b1) busy_seen = 1'b1;
            if (s_ready === 1'b1) sready_seen = 1'b1;
        end
    end

    task automatic clr_stats();
        n_wr = 0; n_done = 0; n_err = 0;
        busy_seen = 1'b0; sready_seen = 1'b0;
    endtask

    task automatic start_load(input int n);
        @(posedge clk); #1;
        start = 1'b1; word_count = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives one byte after `gap` idle cycles; returns #1 after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
            t++;
            if (t > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL byte_timeout: got s_ready %b want 1", s_ready);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d, input int maxgap);
        exp_q.push_back('{a: a, d: d});
        for (int i = 0; i < 4; i++)
            send_byte(d[8*i +: 8], (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (n_done == 0 && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        n_cmp++;
        if (n_done == 0) begin
            n_bad++;
            $display("FAIL done_timeout: got no done, want done within %0d cycles", budget);
        end
    endtask

    task automatic check_end(input string nm, input int wr_exp);
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (n_wr != wr_exp || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_writes: got %0d (pending %0d) want %0d", nm, n_wr, exp_q.size(), wr_exp);
        end
        n_cmp++;
        if (n_done != 1) begin
            n_bad++;
            $display("FAIL %s_done_count: got %0d want 1", nm, n_done);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_busy: got %b want 0", nm, busy);
        end
    endtask

    task automatic check_reset_outs(input string nm);
        n_cmp++;
        if ({s_ready, we, busy, core_hold, done, err} !== 6'b0 || waddr !== '0 || wdata !== '0) begin
            n_bad++;
            $display("FAIL %s: got rdy%b we%b busy%b hold%b done%b err%b wa%0d wd%h want all 0",
                     nm, s_ready, we, busy, core_hold, done, err, waddr, wdata);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset_state");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outs("post_reset_state");
        mon_en = 1'b1;
    endtask

    task automatic test_single_word();
        clr_stats();
        start_load(1);
        exp_q.push_back('{a: '0, d: 32'h0000_0013});
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge clk);
        n_cmp++;
        if (we !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency: got we %b want 1", we);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got done %b busy %b want 1 0", done, busy);
        end
        check_end("single", 1);
    endtask

    task automatic test_three_words_gaps();
        clr_stats();
        start_load(3);
        send_word(0, 32'hdead_beef, 3);
        send_word(1, 32'h0403_0201, 3);
        send_word(2, 32'hffff_ffff, 3);
        wait_done(50);
        check_end("three", 3);
    endtask

    task automatic test_zero_count();
        clr_stats();
        start_load(0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_done: got %b want 1", done);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_seen || n_wr != 0 || n_done != 1) begin
            n_bad++;
            $display("FAIL zero_side: got busy_seen %b writes %0d dones %0d want 0 0 1", busy_seen, n_wr, n_done);
        end
    endtask

    task automatic test_overflow_count();
        clr_stats();
        start_load(DEPTH + 1);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_err: got %b want 1", err);
        end
        s_valid = 1'b1; s_data = 8'haa;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (busy_seen || sready_seen || n_wr != 0 || n_err != 1 || n_done != 0) begin
            n_bad++;
            $display("FAIL ovf_side: got busy %b rdy %b wr %0d err %0d done %0d want 0 0 0 1 0",
                     busy_seen, sready_seen, n_wr, n_err, n_done);
        end
    endtask

    task automatic test_reset_mid_word();
        clr_stats();
        start_load(2);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outs("midreset_outs");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n_wr != 0) begin
            n_bad++;
            $display("FAIL midreset_nowrite: got %0d writes want 0", n_wr);
        end
        clr_stats();
        start_load(1);
        send_word(0, 32'hcafe_f00d, 1);
        wait_done(20);
        check_end("after_reset", 1);
    endtask

    task automatic test_start_ignored();
        clr_stats();
        start_load(2);
        exp_q.push_back('{a: 0, d: 32'h8765_4321});
        send_byte(8'h21, 0);
        start = 1'b1; word_count = (AW+1)'(5);
        send_byte(8'h43, 0); send_byte(8'h65, 0); send_byte(8'h87, 0);
        @(posedge clk); #1;
        start = 1'b0;
        send_word(1, 32'h1234_5678, 0);
        wait_done(20);
        check_end("ignore_start", 2);
    endtask

    task automatic test_full_depth();
        clr_stats();
        start_load(DEPTH);
        for (int i = 0; i < DEPTH; i++)
            send_word(AW'(i), $urandom, 0);
        wait_done(20);
        n_cmp++;
        if (last_wa !== AW'(DEPTH - 1)) begin
            n_bad++;
            $display("FAIL full_last_addr: got %0d want %0d", last_wa, DEPTH - 1);
        end
        check_end("full", DEPTH);
    endtask

    initial begin
        mon_en = 1'b0;
        clr_stats();
        test_reset();
        test_single_word();
        test_three_words_gaps();
        test_zero_count();
        test_overflow_count();
        test_reset_mid_word();
        test_start_ignored();
        test_full_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
